// File: rtl/port_ring_tap_arb_pkg.sv
// Shared definitions for the ring tap: packet control codes, ring word
// field positions and the one-hot state encoding.
package port_ring_tap_arb_pkg;

  localparam logic [1:0] PCC_DATA   = 2'd0;
  localparam logic [1:0] PCC_EOP    = 2'd2;
  localparam logic [1:0] PCC_BADEOP = 2'd3;

  // Ring word is {pvec, pcc[1:0], data[PDP_SZ-1:0]}
  localparam int DATA_LO = 0;
  function automatic int pcc_lo(input int pdp_sz);
    return pdp_sz;
  endfunction
  function automatic int pvec_bit(input int pdp_sz);
    return pdp_sz + 2;
  endfunction

  function automatic logic is_eop(input logic [1:0] pcc);
    return (pcc == PCC_EOP) || (pcc == PCC_BADEOP);
  endfunction

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_RFWD  = 6'b000010,
    ST_RCOPY = 6'b000100,
    ST_RSINK = 6'b001000,
    ST_TDATA = 6'b010000,
    ST_TDROP = 6'b100000
  } state_e;

endpackage

// File: rtl/port_ring_tap_arb_fair_arb.sv
// Local-vs-ring selection in IDLE. fair_cnt counts ring packets that
// overtook a waiting local packet; once it reaches FAIR_LIM local wins.
module ring_tap_fair_arb #(
  parameter int FAIR_LIM = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_idle,
  input  logic lfli_srdy,
  input  logic lri_srdy,
  input  logic ring_take,
  input  logic local_take,
  output logic sel_ring,
  output logic sel_local
);

  localparam int CW = (FAIR_LIM > 0) ? $clog2(FAIR_LIM + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(FAIR_LIM);

  logic [CW-1:0] fair_cnt;
  logic          ring_first;

  // Ring goes first when alone, or while it is still under its allowance
  always_comb begin
    ring_first = lri_srdy & (~lfli_srdy | (fair_cnt < LIM));
    sel_ring   = in_idle & ring_first;
    sel_local  = in_idle & lfli_srdy & ~ring_first;
  end

  // Allowance counter: cleared by any local start, saturating at FAIR_LIM
  always_ff @(posedge clk) begin
    if (reset)
      fair_cnt <= '0;
    else if (local_take)
      fair_cnt <= '0;
    else if (ring_take && lfli_srdy && fair_cnt < LIM)
      fair_cnt <= fair_cnt + 1'b1;
  end

endmodule

// File: rtl/port_ring_tap_arb.sv
// Ring tap: forwards, copies or sinks ring packets addressed by a header
// destination vector, and injects local packets onto the ring.
// Optional PORT_RING_TAP_STATS_EN adds per-outcome 16-bit packet counters.
module port_ring_tap_arb
  import port_ring_tap_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORTNUM   = 0,
  parameter int PDP_SZ    = 64,
  parameter int FAIR_LIM  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lfli_srdy,
  output logic                 lfli_drdy,
  input  logic [NUM_PORTS-1:0] lfli_data,
  input  logic                 lprx_srdy,
  output logic                 lprx_drdy,
  input  logic [PDP_SZ+1:0]    lprx_data,
  output logic                 lptx_srdy,
  input  logic                 lptx_drdy,
  output logic [PDP_SZ+1:0]    lptx_data,
  input  logic                 lri_srdy,
  output logic                 lri_drdy,
  input  logic [PDP_SZ+2:0]    lri_data,
  output logic                 lro_srdy,
  input  logic                 lro_drdy,
  output logic [PDP_SZ+2:0]    lro_data
`ifdef PORT_RING_TAP_STATS_EN
  ,
  output logic [15:0]          stat_fwd,
  output logic [15:0]          stat_sink,
  output logic [15:0]          stat_copy,
  output logic [15:0]          stat_tx,
  output logic [15:0]          stat_drop
`endif
);

  localparam int RW = PDP_SZ + 3;
  localparam int PV = pvec_bit(PDP_SZ);
  localparam int PL = pcc_lo(PDP_SZ);
  localparam logic [NUM_PORTS-1:0] OWN_MASK = NUM_PORTS'(1) << PORTNUM;

  state_e state, nxt;
  logic   blank, en;
  logic   sel_ring, sel_local;
  logic   ri_xfer, lf_xfer, lp_xfer;
  logic   ri_pvec, ri_own;
  logic [1:0] ri_pcc, lp_pcc;
  logic [NUM_PORTS-1:0] ri_rem, lf_vec;
  logic [RW-1:0] hdr_clr, loc_hdr;

  // Field decode and the two rewritten headers
  always_comb begin
    ri_pvec = lri_data[PV];
    ri_pcc  = lri_data[PL +: 2];
    lp_pcc  = lprx_data[PL +: 2];
    ri_own  = |(lri_data[NUM_PORTS-1:0] & OWN_MASK);
    ri_rem  = lri_data[NUM_PORTS-1:0] & ~OWN_MASK;
    lf_vec  = lfli_data & ~OWN_MASK;
    hdr_clr = lri_data;
    hdr_clr[NUM_PORTS-1:0] = ri_rem;
    loc_hdr = '0;
    loc_hdr[PV] = 1'b1;
    loc_hdr[NUM_PORTS-1:0] = lf_vec;
  end

  // Handshakes are blanked during reset and the cycle after it
  assign en      = ~reset & ~blank;
  assign ri_xfer = lri_srdy & lri_drdy;
  assign lf_xfer = lfli_srdy & lfli_drdy;
  assign lp_xfer = lprx_srdy & lprx_drdy;

  ring_tap_fair_arb #(.FAIR_LIM(FAIR_LIM)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .in_idle    (en && state == ST_IDLE),
    .lfli_srdy  (lfli_srdy),
    .lri_srdy   (lri_srdy),
    .ring_take  (state == ST_IDLE && ri_xfer),
    .local_take (state == ST_IDLE && lf_xfer),
    .sel_ring   (sel_ring),
    .sel_local  (sel_local)
  );

  // State register plus post-reset blanking flag
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
    blank <= reset;
  end

  // Next state: packet starts only from IDLE, ends on an EOP/BADEOP transfer
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (ri_xfer) begin
          if (!ri_pvec || !ri_own) nxt = ST_RFWD;
          else if (|ri_rem)        nxt = ST_RCOPY;
          else                     nxt = ST_RSINK;
        end else if (lf_xfer) begin
          nxt = (|lf_vec) ? ST_TDATA : ST_TDROP;
        end
      end
      ST_RFWD, ST_RCOPY, ST_RSINK: if (ri_xfer && is_eop(ri_pcc)) nxt = ST_IDLE;
      ST_TDATA, ST_TDROP:          if (lp_xfer && is_eop(lp_pcc)) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Handshake steering and ring-out data selection
  always_comb begin
    lfli_drdy = 1'b0;
    lprx_drdy = 1'b0;
    lri_drdy  = 1'b0;
    lro_srdy  = 1'b0;
    lptx_srdy = 1'b0;
    lro_data  = lri_data;
    if (en) begin
      case (state)
        ST_IDLE: begin
          if (sel_ring) begin
            if (!ri_pvec || !ri_own) begin
              lro_srdy = 1'b1;
              lri_drdy = lro_drdy;
            end else if (|ri_rem) begin
              lro_srdy = 1'b1;
              lro_data = hdr_clr;
              lri_drdy = lro_drdy;
            end else begin
              lri_drdy = 1'b1;
            end
          end else if (sel_local) begin
            if (|lf_vec) begin
              lro_srdy  = 1'b1;
              lro_data  = loc_hdr;
              lfli_drdy = lro_drdy;
            end else begin
              lfli_drdy = 1'b1;
            end
          end
        end
        ST_RFWD: begin
          lro_srdy = lri_srdy;
          lri_drdy = lro_drdy;
        end
        // Both consumers must be ready so the copy stays word-aligned
        ST_RCOPY: begin
          lro_srdy  = lri_srdy & lptx_drdy;
          lptx_srdy = lri_srdy & lro_drdy;
          lri_drdy  = lro_drdy & lptx_drdy;
        end
        ST_RSINK: begin
          lptx_srdy = lri_srdy;
          lri_drdy  = lptx_drdy;
        end
        ST_TDATA: begin
          lro_srdy  = lprx_srdy;
          lro_data  = {1'b0, lprx_data};
          lprx_drdy = lro_drdy;
        end
        ST_TDROP: lprx_drdy = 1'b1;
        default: ;
      endcase
    end
  end

  assign lptx_data = lri_data[PDP_SZ+1:0];

`ifdef PORT_RING_TAP_STATS_EN
  logic ring_end, tx_end;
  assign ring_end = ri_xfer & is_eop(ri_pcc);
  assign tx_end   = lp_xfer & is_eop(lp_pcc);

  // One count per completed packet, by outcome
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fwd  <= '0;
      stat_sink <= '0;
      stat_copy <= '0;
      stat_tx   <= '0;
      stat_drop <= '0;
    end else begin
      if (state == ST_RFWD  && ring_end) stat_fwd  <= stat_fwd  + 16'd1;
      if (state == ST_RSINK && ring_end) stat_sink <= stat_sink + 16'd1;
      if (state == ST_RCOPY && ring_end) stat_copy <= stat_copy + 16'd1;
      if (state == ST_TDATA && tx_end)   stat_tx   <= stat_tx   + 16'd1;
      if (state == ST_TDROP && tx_end)   stat_drop <= stat_drop + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_port_ring_tap_arb.sv
// Scoreboard bench for port_ring_tap_arb: stream drivers feed queued words,
// a model fills expected lro/lptx queues, a monitor pops on each transfer.
module tb_port_ring_tap_arb;

  localparam int NP  = 4;
  localparam int PN  = 1;
  localparam int PDP = 16;
  localparam int FL  = 2;
  localparam int RW  = PDP + 3;
  localparam int PW  = PDP + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lfli_srdy = 1'b0, lprx_srdy = 1'b0, lri_srdy = 1'b0;
  logic lro_drdy = 1'b0, lptx_drdy = 1'b0;
  logic [NP-1:0] lfli_data = '0;
  logic [PW-1:0] lprx_data = '0;
  logic [RW-1:0] lri_data = '0;
  logic lfli_drdy, lprx_drdy, lptx_srdy, lri_drdy, lro_srdy;
  logic [PW-1:0] lptx_data;
  logic [RW-1:0] lro_data;
`ifdef PORT_RING_TAP_STATS_EN
  logic [15:0] stat_fwd, stat_sink, stat_copy, stat_tx, stat_drop;
`endif

  port_ring_tap_arb #(.NUM_PORTS(NP), .PORTNUM(PN), .PDP_SZ(PDP), .FAIR_LIM(FL)) dut (
    .clk(clk), .reset(reset),
    .lfli_srdy(lfli_srdy), .lfli_drdy(lfli_drdy), .lfli_data(lfli_data),
    .lprx_srdy(lprx_srdy), .lprx_drdy(lprx_drdy), .lprx_data(lprx_data),
    .lptx_srdy(lptx_srdy), .lptx_drdy(lptx_drdy), .lptx_data(lptx_data),
    .lri_srdy(lri_srdy), .lri_drdy(lri_drdy), .lri_data(lri_data),
    .lro_srdy(lro_srdy), .lro_drdy(lro_drdy), .lro_data(lro_data)
`ifdef PORT_RING_TAP_STATS_EN
    , .stat_fwd(stat_fwd), .stat_sink(stat_sink), .stat_copy(stat_copy),
    .stat_tx(stat_tx), .stat_drop(stat_drop)
`endif
  );

  always #5 clk = ~clk;

  logic [RW-1:0] lri_q[$], exp_lro[$];
  logic [NP-1:0] lfli_q[$];
  logic [PW-1:0] lprx_q[$], exp_lptx[$];
  bit gap_en = 0, bp_en = 0, lptx_hold = 0;
  int chk_cnt = 0, pass_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  // Source streams: present queue head, pop after an observed transfer
  always begin : drv_lri
    bit f;
    @(negedge clk); f = lri_srdy && lri_drdy;
    @(posedge clk); #1;
    if (f && lri_q.size() > 0) void'(lri_q.pop_front());
    lri_srdy = (lri_q.size() > 0) && !(gap_en && $urandom_range(3) == 0);
    if (lri_q.size() > 0) lri_data = lri_q[0];
  end

  always begin : drv_lfli
    bit f;
    @(negedge clk); f = lfli_srdy && lfli_drdy;
    @(posedge clk); #1;
    if (f && lfli_q.size() > 0) void'(lfli_q.pop_front());
    lfli_srdy = (lfli_q.size() > 0) && !(gap_en && $urandom_range(3) == 0);
    if (lfli_q.size() > 0) lfli_data = lfli_q[0];
  end

  always begin : drv_lprx
    bit f;
    @(negedge clk); f = lprx_srdy && lprx_drdy;
    @(posedge clk); #1;
    if (f && lprx_q.size() > 0) void'(lprx_q.pop_front());
    lprx_srdy = (lprx_q.size() > 0) && !(gap_en && $urandom_range(3) == 0);
    if (lprx_q.size() > 0) lprx_data = lprx_q[0];
  end

  // Sink backpressure
  always @(posedge clk) begin
    #1;
    lro_drdy  = bp_en ? ($urandom_range(3) != 0) : 1'b1;
    lptx_drdy = lptx_hold ? 1'b0 : (bp_en ? ($urandom_range(3) != 0) : 1'b1);
  end

  // Monitor: every output transfer must match the next expected word
  always @(negedge clk) begin
    if (lro_srdy && lro_drdy) begin
      if (exp_lro.size() == 0) begin
        chk_cnt++;
        $display("FAIL lro_unexpected: got %h expected none", lro_data);
      end else chk("lro_word", lro_data, exp_lro.pop_front());
    end
    if (lptx_srdy && lptx_drdy) begin
      if (exp_lptx.size() == 0) begin
        chk_cnt++;
        $display("FAIL lptx_unexpected: got %h expected none", lptx_data);
      end else chk("lptx_word", lptx_data, exp_lptx.pop_front());
    end
  end

  function automatic logic [1:0] end_pcc();
    return ($urandom_range(1) == 1) ? 2'd2 : 2'd3;
  endfunction

  // Model: ring packet outcome from own bit and remaining destinations
  task automatic send_ring(input logic [NP-1:0] vec, input int n);
    logic [RW-1:0] hdr, w;
    logic [NP-1:0] rem;
    logic own;
    logic [1:0] pcc;
    own = vec[PN];
    rem = vec & ~(NP'(1) << PN);
    hdr = '0; hdr[RW-1] = 1'b1; hdr[NP-1:0] = vec;
    lri_q.push_back(hdr);
    if (!own) exp_lro.push_back(hdr);
    else if (rem != 0) begin hdr[NP-1:0] = rem; exp_lro.push_back(hdr); end
    for (int i = 0; i < n; i++) begin
      pcc = (i == n - 1) ? end_pcc() : 2'd0;
      w = {1'b0, pcc, 16'($urandom)};
      lri_q.push_back(w);
      if (!own || rem != 0) exp_lro.push_back(w);
      if (own) exp_lptx.push_back(w[PW-1:0]);
    end
  endtask

  // Model: local packet is injected unless only this port was addressed
  task automatic send_local(input logic [NP-1:0] vec, input int n);
    logic [RW-1:0] hdr;
    logic [PW-1:0] w;
    logic [NP-1:0] v;
    logic [1:0] pcc;
    v = vec & ~(NP'(1) << PN);
    lfli_q.push_back(vec);
    hdr = '0; hdr[RW-1] = 1'b1; hdr[NP-1:0] = v;
    if (v != 0) exp_lro.push_back(hdr);
    for (int i = 0; i < n; i++) begin
      pcc = (i == n - 1) ? end_pcc() : 2'd0;
      w = {pcc, 16'($urandom)};
      lprx_q.push_back(w);
      if (v != 0) exp_lro.push_back({1'b0, w});
    end
  endtask

  function automatic bit all_empty();
    return lri_q.size() == 0 && lfli_q.size() == 0 && lprx_q.size() == 0 &&
           exp_lro.size() == 0 && exp_lptx.size() == 0;
  endfunction

  task automatic wait_done(input string nm, input int budget, input bit quiet);
    int c = 0;
    bit done = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      if (quiet) chk({nm, "_lro_quiet"}, 64'(lro_srdy), 64'd0);
      c++;
      done = all_empty();
    end
    chk({nm, "_drain"}, 64'(done), 64'd1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  function automatic logic [4:0] hs();
    return {lfli_drdy, lprx_drdy, lptx_srdy, lri_drdy, lro_srdy};
  endfunction

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    int nr, nl, cnt, c;
    // Reset: handshakes held low even with a local packet pending
    send_local(4'b1010, 3);
    repeat (3) begin @(negedge clk); chk("reset_hs", 64'(hs()), 64'd0); end
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk); chk("post_reset_hs", 64'(hs()), 64'd0);
    wait_done("local_tx", 200, 0);

    // Ring copy, then lptx stall must freeze both sides
    send_ring(4'b0110, 4);
    c = 0;
    while (exp_lptx.size() > 3 && c < 100) begin @(posedge clk); #2; c++; end
    chk("copy_started", 64'(exp_lptx.size() <= 3), 64'd1);
    lptx_hold = 1;
    @(posedge clk); #2;
    repeat (5) begin
      @(negedge clk);
      chk("stall_lro", 64'(lro_srdy && lro_drdy), 64'd0);
      chk("stall_lptx", 64'(lptx_srdy && lptx_drdy), 64'd0);
      chk("stall_lri", 64'(lri_drdy), 64'd0);
    end
    lptx_hold = 0;
    wait_done("ring_copy", 200, 0);

    send_ring(4'b0010, 3);
    wait_done("ring_sink", 200, 1);
    send_local(4'b0010, 4);
    wait_done("local_drop", 200, 1);
    send_ring(4'b1001, 2);
    wait_done("ring_fwd", 200, 0);

    // Fairness: both sources continuously pending
    do_reset();
    nr = 4; nl = 2; cnt = 0;
    while (nr > 0 || nl > 0) begin
      if (nr > 0 && (nl == 0 || cnt < FL)) begin
        send_ring(4'b0100, 2); nr--;
        if (nl > 0 && cnt < FL) cnt++;
      end else begin
        send_local(4'b1000, 2); nl--; cnt = 0;
      end
    end
    wait_done("fair_order", 400, 0);

    // Reset in the middle of a ring copy, then a fresh packet
    do_reset();
    send_ring(4'b0110, 6);
    c = 0;
    while (exp_lptx.size() > 4 && c < 100) begin @(posedge clk); #2; c++; end
    chk("copy_mid", 64'(exp_lptx.size() <= 4), 64'd1);
    reset = 1'b1;
    lri_q.delete(); exp_lro.delete(); exp_lptx.delete();
    send_ring(4'b0110, 2);
    @(negedge clk); chk("midrst_hs", 64'(hs()), 64'd0);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk); chk("midrst_next_hs", 64'(hs()), 64'd0);
    wait_done("after_reset", 200, 0);

    // Randomized single-source packets with gaps and backpressure
    gap_en = 1; bp_en = 1;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(1) == 1) send_ring(4'($urandom_range(15)), $urandom_range(1, 4));
      else send_local(4'($urandom_range(15)), $urandom_range(1, 4));
      wait_done("random", 400, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/port_ring_tap_arb.md
PORT_RING_TAP_ARB -- requirements
Module: port_ring_tap_arb

Interface
REQ-001 Parameters (name, default, meaning): NUM_PORTS, 4, ring port count; PORTNUM, 0, this tap's index (0..NUM_PORTS-1); PDP_SZ, 64, payload width; FAIR_LIM, 0, ring packets allowed ahead of a waiting local packet (0 = strict local priority).
REQ-002 Ring word RW = PDP_SZ+3 = {pvec[1], pcc[2], data[PDP_SZ]}; port word PW = PDP_SZ+2 = {pcc, data}.
REQ-003 Ports (name direction width meaning): clk in 1 clock; reset in 1 synchronous active-high reset; lfli_srdy in 1, lfli_drdy out 1, lfli_data in NUM_PORTS destination vector for the local packet; lprx_srdy in 1, lprx_drdy out 1, lprx_data in PW local receive data; lptx_srdy out 1, lptx_drdy in 1, lptx_data out PW local transmit data; lri_srdy in 1, lri_drdy out 1, lri_data in RW ring in; lro_srdy out 1, lro_drdy in 1, lro_data out RW ring out.
REQ-004 All interfaces use srdy/drdy; a word transfers on a cycle with both high.

Function
REQ-005 Header word: pvec=1, pcc=0, data[NUM_PORTS-1:0] = destination vector, upper data bits zero; payload words: pvec=0; packet ends on a payload word with pcc EOP(2) or BADEOP(3).
REQ-006 States, one-hot: IDLE, RFWD, RCOPY, RSINK, TDATA, TDROP.
REQ-007 IDLE, local selected with lfli vector v' = lfli_data & ~(1<<PORTNUM) nonzero: emit header with v' on lro; on lro_drdy pop lfli, go TDATA.
REQ-008 IDLE, local selected with v' zero: pop lfli, go TDROP.
REQ-009 IDLE, ring header selected, own bit clear: forward header unchanged on lro_drdy, go RFWD.
REQ-010 IDLE, ring header, own bit set, remaining vector nonzero: forward header with own bit cleared on lro_drdy, go RCOPY; remaining vector zero: consume header immediately, go RSINK.
REQ-011 TDATA: pass lprx to lro with pvec=0; EOP/BADEOP transfer -> IDLE.
REQ-012 TDROP: lprx_drdy=1, nothing emitted; EOP/BADEOP transfer -> IDLE.
REQ-013 RFWD: lri to lro unchanged; RSINK: lri payload to lptx only; RCOPY: lri to lro and lptx, transfer only when lri_srdy & lro_drdy & lptx_drdy all high (atomic); each -> IDLE on EOP/BADEOP transfer.
REQ-014 Header never presented on lptx; lptx_data = lri_data[PW-1:0].
REQ-015 Arbitration when lfli_srdy and lri_srdy both high in IDLE: ring wins while fair_cnt < FAIR_LIM, else local wins.
REQ-016 fair_cnt (width clog2(FAIR_LIM+1), min 1): +1 when a ring header is accepted while lfli_srdy high; cleared when a local header/drop starts; saturates at FAIR_LIM.
REQ-017 Only one source enabled: that source is served regardless of fair_cnt.
REQ-018 A packet never interleaves with another on lro; arbitration happens only in IDLE.
REQ-019 Decisions are combinational from state and inputs; zero-cycle latency in non-IDLE states, one header cycle per packet.
REQ-020 Non-pvec word seen in IDLE on lri: forwarded as RFWD start (no drop).

Reset
REQ-021 On reset: state=IDLE, fair_cnt=0, all srdy/drdy outputs 0 in the following cycle, data outputs don't-care; reset mid-packet abandons it without further transfers.

Configuration
REQ-022 PORT_RING_TAP_STATS_EN defined: adds outputs stat_fwd, stat_sink, stat_copy, stat_tx, stat_drop (each 16 bits, wrapping), incremented once per packet at the EOP transfer in RFWD, RSINK, RCOPY, TDATA, TDROP respectively, cleared by reset; undefined: ports and counters absent, behaviour otherwise identical.

Structure
REQ-023 Shared package holds PCC codes (DATA=0, EOP=2, BADEOP=3), ring field positions (PVEC, PCC, DATA) and the state encoding.
REQ-024 One sub-module, ring_tap_fair_arb, holds fair_cnt and the IDLE selection.

Verification
REQ-025 NUM_PORTS=4, PORTNUM=1, local packet vector 4'b1010, 3 words -> header vector 4'b1000, 3 payload words on lro, IDLE after EOP.
REQ-026 Ring header 4'b0110 -> header 4'b0100 forwarded, payload on lro and lptx; lptx_drdy low 5 cycles -> no transfer on either side.
REQ-027 Ring header 4'b0010 -> RSINK, payload only on lptx, lro_srdy held 0.
REQ-028 Local vector 4'b0010 -> lfli popped, 4-word lprx packet drained, nothing on lro.
REQ-029 FAIR_LIM=2, lfli and lri continuously pending -> ring, ring, local, ring, ring, local order.
REQ-030 Reset asserted mid-RCOPY -> next cycle all srdy/drdy 0, state IDLE, new header accepted normally.
